lr_receiver: RTL and testbench
==============================

# lr_receiver

Receiver stage of the LeakyRand covert-channel datapath. Turns a stream of per-bit probe-latency samples into a decoded bit string. Writes bit positions `eos` through `STR_LEN-1`, then raises `outstring_ready` and holds `out_string` stable for the downstream string comparator, which counts bit errors over the same index range.

## Interface
Parameters:
- `STR_LEN`, default 64 — string length in bits (matches the shared macro).
- `LOG_STR_LEN`, default 6 — log2(`STR_LEN`).
- `LAT_W`, default 8 — width of a latency sample.
- `THRESH`, default 8'd100 — decode threshold.
  - `sample_lat > THRESH` decodes to bit 1 (miss).
  - Otherwise the bit decodes to 0 (hit).

Ports:
- `clk` — input, 1 — single clock; everything is on its rising edge.
- `rst` — input, 1 — reset, synchronous and active-high.
- `start` — input, 1 — begin a reception; sampled in IDLE and DONE only.
- `eos` — input, `LOG_STR_LEN` — first bit index to receive; latched on an accepted `start`.
- `sample_valid` — input, 1 — a latency sample is presented.
- `sample_lat` — input, `LAT_W` — probe latency of the current bit.
- `sample_ready` — output, 1 — high exactly in RECV.
- `out_string` — output, `STR_LEN` — decoded string.
- `outstring_ready` — output, 1 — high exactly in DONE.
- `bit_idx` — output, `LOG_STR_LEN+1` — next bit position to be written (debug and verification).

## Operation
FSM states and transitions:
- **IDLE → RECV** on `start`.
  - Latch `bit_idx <= {1'b0, eos}`.
  - Clear `out_string` to 0.
- **RECV:**
  - A sample is accepted when `sample_valid && sample_ready`.
  - On the accepted sample that completes a bit, write the decoded bit to `out_string[bit_idx]` and increment `bit_idx`.
  - **RECV → DONE** on the write where `bit_idx == STR_LEN-1`. `bit_idx` reaches `STR_LEN`.
- **DONE:**
  - `out_string` and `outstring_ready` are held indefinitely.
  - `start` re-arms as in IDLE: the string is cleared, `outstring_ready` falls, and the FSM goes to RECV.

Boundary rules:
- Bits below `eos` are always 0.
- `eos = STR_LEN-1` takes exactly one bit.
- `eos = 0` takes `STR_LEN` bits.
- `start` in RECV is ignored and `eos` is not re-latched.
- `sample_valid` in IDLE or DONE is ignored. There is no buffering.
- `sample_lat` is compared unsigned against `THRESH` at full `LAT_W` width.
- `bit_idx` is `LOG_STR_LEN+1` bits wide, so the value `STR_LEN` is representable. It never exceeds `STR_LEN`.

## Timing
- Reset values:
  - FSM state: IDLE.
  - `out_string`: 0.
  - `outstring_ready`: 0.
  - `sample_ready`: 0.
  - `bit_idx`: 0.
- `rst` wins over every other input in the same cycle.
  - Mid-reception: everything returns to the reset values on the next edge and the partial string is discarded.
- `start` at edge N → `sample_ready` is high from cycle N+1.
- Throughput: one sample accepted per cycle.
- The accepted sample at edge N is visible in `out_string` at cycle N+1.
- The final completing sample at edge N → `outstring_ready` = 1 and `sample_ready` = 0 from cycle N+1.
  - `out_string` is already final in that same cycle.
  - `out_string` does not change while `outstring_ready` is high.

## Configuration
- `LR_RX_MAJORITY_EN` defined:
  - Each bit consumes 3 accepted samples.
  - A 2-bit vote counter and a 2-bit ones counter are kept per bit.
  - The bit value is `ones >= 2`. It is written on the third sample, and then both counters clear.
  - Counters also clear on `start` and `rst`.
  - `sample_ready` stays high across all 3 samples of a bit.
- `LR_RX_MAJORITY_EN` undefined:
  - One sample per bit.
  - No vote logic is synthesised.

## Structure
- `STR_LEN`, `LOG_STR_LEN`, `LAT_W`, `THRESH` defaults and the FSM state encodings (IDLE=2'd0, RECV=2'd1, DONE=2'd2) live in the shared `macros.v`.
- One sub-module: `lr_bit_decoder`.
  - Contains the threshold compare and the optional majority vote.
  - Outputs `bit_valid` and `bit_val` to the FSM.
  - The FSM and string register stay in `lr_receiver`.

## Test plan
- **Full string:** `rst`, then `start` with `eos=0`, then 64 samples alternating 200 and 10.
  - `out_string = 64'h5555_5555_5555_5555`.
  - `outstring_ready` rises the cycle after sample 64.
- **Short tail:** `eos=60`, samples 200, 200, 10, 200.
  - Bits [63:60] = 4'b1011, bits [59:0] = 0.
  - Done after exactly 4 accepted samples.
- **Threshold edge:** `sample_lat = 100` → bit 0; `101` → bit 1; `255` → bit 1.
- **Reset and stray inputs:** assert `rst` after 10 of 64 samples.
  - Next cycle: all outputs are at their reset values.
  - `sample_valid` pulses while in IDLE leave `out_string` = 0.
- **Ignored and re-armed `start`:** `start` with `eos=5` mid-RECV (entered with `eos=0`) → ignored, and all 64 bits are still collected.
  - `start` in DONE → `outstring_ready` falls the next cycle and `out_string` is cleared.
- **Majority vote (`LR_RX_MAJORITY_EN` defined):** `eos=62`, samples 200, 10, 200, then 10, 10, 200.
  - Bit 62 = 1, bit 63 = 0.
  - Done after 6 samples.

Source files
------------

// File: rtl/lr_receiver_pkg.sv
// Shared defaults and FSM encoding for the LeakyRand receiver stage.
package lr_receiver_pkg;

  localparam int          LR_STR_LEN     = 64;
  localparam int          LR_LOG_STR_LEN = 6;
  localparam int          LR_LAT_W       = 8;
  localparam logic [7:0]  LR_THRESH      = 8'd100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } lr_state_e;

endpackage

// File: rtl/lr_receiver_if.sv
// Sample stream in, decoded string out; master = sample source, slave = receiver.
interface lr_receiver_if
  import lr_receiver_pkg::*;
#(
  parameter int STR_LEN     = LR_STR_LEN,
  parameter int LOG_STR_LEN = LR_LOG_STR_LEN,
  parameter int LAT_W       = LR_LAT_W
) ();

  logic                   start;
  logic [LOG_STR_LEN-1:0] eos;
  logic                   sample_valid;
  logic [LAT_W-1:0]       sample_lat;
  logic                   sample_ready;
  logic [STR_LEN-1:0]     out_string;
  logic                   outstring_ready;
  logic [LOG_STR_LEN:0]   bit_idx;

  modport master (
    output start, eos, sample_valid, sample_lat,
    input  sample_ready, out_string, outstring_ready, bit_idx
  );

  modport slave (
    input  start, eos, sample_valid, sample_lat,
    output sample_ready, out_string, outstring_ready, bit_idx
  );

endinterface

// File: rtl/lr_bit_decoder.sv
// Latency-to-bit decode; optional 3-sample majority vote under LR_RX_MAJORITY_EN.
module lr_bit_decoder
  import lr_receiver_pkg::*;
#(
  parameter int               LAT_W  = LR_LAT_W,
  parameter logic [LAT_W-1:0] THRESH = LAT_W'(LR_THRESH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_accept,
  input  logic [LAT_W-1:0] i_lat,
  output logic             o_bit_valid,
  output logic             o_bit_val
);

  logic w_miss;
  assign w_miss = (i_lat > THRESH);

`ifdef LR_RX_MAJORITY_EN
  logic [1:0] r_vote_cnt;
  logic [1:0] r_ones_cnt;
  logic       w_third;

  assign w_third = i_accept && (r_vote_cnt == 2'd2);

  always_ff @(posedge clk) begin
    if (rst || i_clear || w_third) begin
      r_vote_cnt <= 2'd0;
      r_ones_cnt <= 2'd0;
    end else if (i_accept) begin
      r_vote_cnt <= r_vote_cnt + 2'd1;
      r_ones_cnt <= r_ones_cnt + {1'b0, w_miss};
    end
  end

  // Third sample's vote is folded in combinationally so the bit lands on that edge.
  assign o_bit_valid = w_third;
  assign o_bit_val   = (({1'b0, r_ones_cnt} + {2'b00, w_miss}) >= 3'd2);
`else
  logic w_unused;
  assign w_unused    = &{1'b0, clk, rst, i_clear};
  assign o_bit_valid = i_accept;
  assign o_bit_val   = w_miss;
`endif

endmodule

// File: rtl/lr_receiver.sv
// LeakyRand receiver: fills out_string[eos..STR_LEN-1] from decoded latency samples.
// Build option: LR_RX_MAJORITY_EN (3-sample majority vote per bit).
//
//   state   | meaning
//   IDLE    | waiting for start, samples ignored
//   RECV    | accepting samples, writing bits at bit_idx
//   DONE    | string final and held, start re-arms
module lr_receiver
  import lr_receiver_pkg::*;
#(
  parameter int               STR_LEN     = LR_STR_LEN,
  parameter int               LOG_STR_LEN = LR_LOG_STR_LEN,
  parameter int               LAT_W       = LR_LAT_W,
  parameter logic [LAT_W-1:0] THRESH      = LAT_W'(LR_THRESH)
) (
  input  logic         clk,
  input  logic         rst,
  lr_receiver_if.slave bus
);

  lr_state_e            r_state;
  lr_state_e            w_state_nxt;
  logic [STR_LEN-1:0]   r_string;
  logic [LOG_STR_LEN:0] r_bit_idx;
  logic                 w_start_acc;
  logic                 w_accept;
  logic                 w_bit_valid;
  logic                 w_bit_val;
  logic                 w_last_bit;
  logic                 w_sample_ready;
  logic                 w_done;

  assign w_start_acc = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_accept    = bus.sample_valid && (r_state == ST_RECV);
  assign w_last_bit  = w_bit_valid && (r_bit_idx == (LOG_STR_LEN+1)'(STR_LEN-1));

  lr_bit_decoder #(
    .LAT_W  (LAT_W),
    .THRESH (THRESH)
  ) u_dec (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_start_acc),
    .i_accept    (w_accept),
    .i_lat       (bus.sample_lat),
    .o_bit_valid (w_bit_valid),
    .o_bit_val   (w_bit_val)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start)  w_state_nxt = ST_RECV;
      ST_RECV: if (w_last_bit) w_state_nxt = ST_DONE;
      ST_DONE: if (bus.start)  w_state_nxt = ST_RECV;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sample_ready = 1'b0;
    w_done         = 1'b0;
    case (r_state)
      ST_RECV: w_sample_ready = 1'b1;
      ST_DONE: w_done         = 1'b1;
      default: ;
    endcase
  end

  // bit_idx only moves while in RECV, so the string is frozen in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_string  <= '0;
      r_bit_idx <= '0;
    end else if (w_start_acc) begin
      r_string  <= '0;
      r_bit_idx <= {1'b0, bus.eos};
    end else if (w_bit_valid) begin
      r_string[r_bit_idx[LOG_STR_LEN-1:0]] <= w_bit_val;
      r_bit_idx                            <= r_bit_idx + 1'b1;
    end
  end

  assign bus.sample_ready    = w_sample_ready;
  assign bus.outstring_ready = w_done;
  assign bus.out_string      = r_string;
  assign bus.bit_idx         = r_bit_idx;

endmodule

// File: tb/tb_lr_receiver.sv
// Bench for lr_receiver: expected strings queued at stimulus time, popped at completion.
module tb_lr_receiver;

`ifdef LR_RX_MAJORITY_EN
  localparam int SPB = 3;
`else
  localparam int SPB = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0]  lat_q[$];
  logic [63:0] sb_q[$];

  lr_receiver_if #(.STR_LEN(64), .LOG_STR_LEN(6), .LAT_W(8)) bus ();

  lr_receiver #(
    .STR_LEN(64), .LOG_STR_LEN(6), .LAT_W(8), .THRESH(8'd100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bit(input logic [7:0] lat);
    for (int s = 0; s < SPB; s++) lat_q.push_back(lat);
  endtask

  task automatic do_start(input int e);
    bus.start = 1'b1;
    bus.eos   = 6'(e);
    tick();
    bus.start = 1'b0;
    check_val("start_srdy", bus.sample_ready, 1);
    check_val("start_idx", bus.bit_idx, e);
  endtask

  // Runs one reception from eos e over lat_q; ign_at injects a stray start (eos=5).
  task automatic run_rx(input int e, input int ign_at);
    logic [63:0] exp;
    int          ones;
    int          n;
    exp = '0;
    for (int b = 0; b < 64 - e; b++) begin
      ones = 0;
      for (int s = 0; s < SPB; s++) if (lat_q[b*SPB+s] > 8'd100) ones++;
      exp[e+b] = (ones * 2 > SPB);
    end
    sb_q.push_back(exp);
    do_start(e);
    n = lat_q.size();
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) check_val("not_done_early", bus.outstring_ready, 0);
      if (i == ign_at) begin
        bus.start = 1'b1;
        bus.eos   = 6'd5;
      end
      bus.sample_valid = 1'b1;
      bus.sample_lat   = lat_q[i];
      tick();
      bus.start = 1'b0;
      if (i == SPB - 1) check_val("first_bit_vis", bus.out_string[e], exp[e]);
    end
    bus.sample_valid = 1'b0;
    check_val("done_timing", bus.outstring_ready, 1);
    for (int w = 0; w < 8 && !bus.outstring_ready; w++) tick();
    check_val("sb_string", bus.out_string, sb_q.pop_front());
    check_val("done_idx", bus.bit_idx, 64);
    check_val("done_srdy", bus.sample_ready, 0);
    lat_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] held;
    bus.start        = 1'b0;
    bus.eos          = '0;
    bus.sample_valid = 1'b0;
    bus.sample_lat   = '0;
    tick();
    tick();
    rst = 1'b0;
    check_val("rst_string", bus.out_string, 0);
    check_val("rst_odone", bus.outstring_ready, 0);
    check_val("rst_srdy", bus.sample_ready, 0);
    check_val("rst_idx", bus.bit_idx, 0);

    // full string alternating miss/hit
    for (int i = 0; i < 64; i++) push_bit((i % 2 == 0) ? 8'd200 : 8'd10);
    run_rx(0, -1);
    check_val("full_const", bus.out_string, 64'h5555_5555_5555_5555);

    // held in DONE, stray samples ignored
    held = bus.out_string;
    bus.sample_valid = 1'b1;
    bus.sample_lat   = 8'd10;
    repeat (3) tick();
    bus.sample_valid = 1'b0;
    check_val("done_hold", bus.out_string, held);
    check_val("done_stays", bus.outstring_ready, 1);

    // short tail
    push_bit(8'd200); push_bit(8'd200); push_bit(8'd10); push_bit(8'd200);
    run_rx(60, -1);
    check_val("tail_const", bus.out_string, 64'hB000_0000_0000_0000);

    // threshold edge
    push_bit(8'd100); push_bit(8'd101); push_bit(8'd255);
    run_rx(61, -1);
    check_val("thresh_const", bus.out_string, 64'hC000_0000_0000_0000);

    // single bit at eos = STR_LEN-1
    push_bit(8'd150);
    run_rx(63, -1);
    check_val("eos63_const", bus.out_string, 64'h8000_0000_0000_0000);

    // reset mid-reception, rst wins over a concurrent sample
    do_start(0);
    for (int i = 0; i < 10 * SPB; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_lat   = 8'd200;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.sample_valid = 1'b0;
    check_val("mid_rst_string", bus.out_string, 0);
    check_val("mid_rst_srdy", bus.sample_ready, 0);
    check_val("mid_rst_idx", bus.bit_idx, 0);
    check_val("mid_rst_odone", bus.outstring_ready, 0);
    bus.sample_valid = 1'b1;
    bus.sample_lat   = 8'd255;
    repeat (4) tick();
    bus.sample_valid = 1'b0;
    check_val("idle_stray_string", bus.out_string, 0);
    check_val("idle_stray_idx", bus.bit_idx, 0);

    // start in RECV ignored, random payload
    for (int i = 0; i < 64; i++) push_bit(8'($urandom_range(0, 255)));
    run_rx(0, 20 * SPB);

    // start in DONE re-arms
    bus.start = 1'b1;
    bus.eos   = 6'd3;
    tick();
    bus.start = 1'b0;
    check_val("rearm_odone", bus.outstring_ready, 0);
    check_val("rearm_string", bus.out_string, 0);
    check_val("rearm_idx", bus.bit_idx, 3);
    for (int i = 0; i < 61; i++) push_bit(8'($urandom_range(0, 255)));
    run_rx(3, -1);
    check_val("rearm_low_zero", bus.out_string[2:0], 0);

`ifdef LR_RX_MAJORITY_EN
    lat_q.push_back(8'd200); lat_q.push_back(8'd10);  lat_q.push_back(8'd200);
    lat_q.push_back(8'd10);  lat_q.push_back(8'd10);  lat_q.push_back(8'd200);
    run_rx(62, -1);
    check_val("maj_const", bus.out_string, 64'h4000_0000_0000_0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
